// File: rtl/mul_pkg.sv
// Shared types and widths for the multiplier pool scheduler.
package mul_pkg;
  localparam int A_W   = 16;
  localparam int C_W   = 32;
  localparam int OWN_W = 8;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_BUSY = 2'd1,
    SLOT_DONE = 2'd2
  } slot_state_e;

  // Operand b is kept beside this struct because its width follows the pool's N.
  typedef struct packed {
    slot_state_e      state;
    logic [OWN_W-1:0] owner;
    logic [A_W-1:0]   a;
    logic [C_W-1:0]   c;
  } slot_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at a rotating pointer.
module rr_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] req,
  input  logic         en,
  output logic [W-1:0] gnt
);
  localparam int PW = (W > 1) ? $clog2(W) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic          found;
    int            idx_full;
    logic [PW-1:0] idx;
    found    = 1'b0;
    idx_full = 0;
    idx      = '0;
    gnt      = '0;
    ptr_d    = ptr_q;
    if (en) begin
      for (int i = 0; i < W; i++) begin
        idx_full = (int'(ptr_q) + i) % W;
        idx      = PW'(idx_full);
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          ptr_d    = PW'((idx_full + 1) % W);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/mul_pool_sched.sv
// Shares NUM_MUL multiplier slots among NUM_REQ requesters; results are held per slot
// until the owning requester accepts them.
//  state     | meaning
//  SLOT_IDLE | free, may be dispatched to
//  SLOT_BUSY | operands driven to the multiplier, waiting for done
//  SLOT_DONE | product latched, waiting for the owner to accept
module mul_pool_sched
  import mul_pkg::*;
#(
  parameter int N       = 4,
  parameter int NUM_REQ = 4,
  parameter int NUM_MUL = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_vld_i,
  input  logic [NUM_REQ-1:0][A_W-1:0]      req_a_i,
  input  logic [NUM_REQ-1:0][N-1:0]        req_b_i,
  output logic [NUM_REQ-1:0]               req_rdy_o,
  output logic [NUM_REQ-1:0]               rsp_vld_o,
  output logic [NUM_REQ-1:0][C_W-1:0]      rsp_c_o,
  input  logic [NUM_REQ-1:0]               rsp_rdy_i,
  output logic [NUM_MUL-1:0][A_W-1:0]      mul_a_o,
  output logic [NUM_MUL-1:0][N-1:0]        mul_b_o,
  output logic [NUM_MUL-1:0]               mul_vld_o,
  input  logic [NUM_MUL-1:0][C_W-1:0]      mul_c_i,
  input  logic [NUM_MUL-1:0]               mul_done_i,
  output logic [$clog2(NUM_MUL+1)-1:0]     busy_cnt_o
);
  localparam int CNT_W = $clog2(NUM_MUL + 1);
  localparam int SEL_W = (NUM_MUL > 1) ? $clog2(NUM_MUL) : 1;

  slot_t [NUM_MUL-1:0]               slot_q, slot_d;
  logic  [NUM_MUL-1:0][N-1:0]        b_q, b_d;
  logic  [NUM_MUL-1:0]               mul_vld_q, mul_vld_d;
  logic  [NUM_REQ-1:0]               rsp_vld_q, rsp_vld_d;
  logic  [NUM_REQ-1:0][C_W-1:0]      rsp_c_q, rsp_c_d;
  logic  [CNT_W-1:0]                 busy_cnt_q, busy_cnt_d;
  logic                              run_q;

  logic [NUM_REQ-1:0] owned, gnt;
  logic               idle_any, win_vld;
  logic [SEL_W-1:0]   sel;
  logic [A_W-1:0]     win_a;
  logic [N-1:0]       win_b;
  logic [OWN_W-1:0]   win_own;

  // Descending scan so the lowest-index idle slot is the one left in sel.
  always_comb begin
    owned    = '0;
    idle_any = 1'b0;
    sel      = '0;
    for (int m = NUM_MUL - 1; m >= 0; m--) begin
      if (slot_q[m].state == SLOT_IDLE) begin
        idle_any = 1'b1;
        sel      = SEL_W'(m);
      end else begin
        for (int r = 0; r < NUM_REQ; r++)
          if (slot_q[m].owner == OWN_W'(r)) owned[r] = 1'b1;
      end
    end
  end

  // run_q holds grants off while reset is asserted and in the cycle it releases.
  rr_arbiter #(.W(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_vld_i & ~owned),
    .en    (idle_any & run_q),
    .gnt   (gnt)
  );

  assign req_rdy_o = gnt;
  assign win_vld   = |gnt;

  always_comb begin
    win_a   = '0;
    win_b   = '0;
    win_own = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (gnt[r]) begin
        win_a   = req_a_i[r];
        win_b   = req_b_i[r];
        win_own = OWN_W'(r);
      end
    end
  end

  always_comb begin
    slot_d    = slot_q;
    b_d       = b_q;
    mul_vld_d = '0;
    for (int m = 0; m < NUM_MUL; m++) begin
      case (slot_q[m].state)
        SLOT_IDLE: begin
          if (win_vld && sel == SEL_W'(m)) begin
            slot_d[m].state = SLOT_BUSY;
            slot_d[m].owner = win_own;
            slot_d[m].a     = win_a;
            b_d[m]          = win_b;
            mul_vld_d[m]    = 1'b1;
          end
        end
        SLOT_BUSY: begin
          if (mul_done_i[m]) begin
            slot_d[m].state = SLOT_DONE;
            slot_d[m].c     = mul_c_i[m];
          end
        end
        SLOT_DONE: begin
          for (int r = 0; r < NUM_REQ; r++)
            if (slot_q[m].owner == OWN_W'(r) && rsp_vld_q[r] && rsp_rdy_i[r])
              slot_d[m].state = SLOT_IDLE;
        end
        default: slot_d[m].state = SLOT_IDLE;
      endcase
    end
  end

  // Responses and the busy count follow next-state so they line up with slot_q.
  always_comb begin
    rsp_vld_d  = '0;
    rsp_c_d    = '0;
    busy_cnt_d = '0;
    for (int m = 0; m < NUM_MUL; m++) begin
      if (slot_d[m].state != SLOT_IDLE) busy_cnt_d = busy_cnt_d + CNT_W'(1);
      if (slot_d[m].state == SLOT_DONE) begin
        for (int r = 0; r < NUM_REQ; r++) begin
          if (slot_d[m].owner == OWN_W'(r)) begin
            rsp_vld_d[r] = 1'b1;
            rsp_c_d[r]   = slot_d[m].c;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= '0;
      b_q        <= '0;
      mul_vld_q  <= '0;
      rsp_vld_q  <= '0;
      rsp_c_q    <= '0;
      busy_cnt_q <= '0;
      run_q      <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      b_q        <= b_d;
      mul_vld_q  <= mul_vld_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_c_q    <= rsp_c_d;
      busy_cnt_q <= busy_cnt_d;
      run_q      <= 1'b1;
    end
  end

  always_comb begin
    mul_a_o = '0;
    for (int m = 0; m < NUM_MUL; m++) mul_a_o[m] = slot_q[m].a;
  end

  assign mul_b_o    = b_q;
  assign mul_vld_o  = mul_vld_q;
  assign rsp_vld_o  = rsp_vld_q;
  assign rsp_c_o    = rsp_c_q;
  assign busy_cnt_o = busy_cnt_q;
endmodule
